alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised sequential ALU; successor to the 4-bit combinational ALU.
- Same 3-bit opcode set: ADD, SUB, AND, OR, XOR, NOT, SHL, SHR.
- Adds WIDTH generalisation, valid/ready handshakes on input and output, a registered result, and a full flag set.
- Shifts are iterative: one bit per cycle, variable amount. Sits between the operand issue logic and the writeback stage.

Parameters:
WIDTH, 8, operand/result width in bits (>=2); localparam CNT_W = $clog2(WIDTH)+1 for the shift counter.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand/op presented
in_ready  output  1  block can accept this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B / shift amount (unsigned)
op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(a), 6 SHL, 7 SHR (logical)
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
carry  output  1  ADD carry-out; SUB borrow (1 when a<b unsigned); SHL/SHR last bit shifted out; 0 otherwise
zero  output  1  result == 0
negative  output  1  result[WIDTH-1]
overflow  output  1  signed overflow for ADD/SUB; 0 otherwise

Behaviour:
- Handshake:
  - Input accepted when in_valid && in_ready. a, b and op are sampled only at accept.
  - Output transfers when out_valid && out_ready.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - HOLD: out_valid=1, in_ready=out_ready.
- Transitions:
  - IDLE, accept, non-shift op: compute via core and register; next state HOLD. Latency 1 cycle.
  - IDLE, accept, SHL/SHR: load working reg=a and cnt=min(b,WIDTH).
    - cnt==0: go to HOLD directly, result=a, carry=0.
    - Otherwise go to BUSY.
  - BUSY: each cycle shift working reg by 1, capture shifted-out bit into carry, decrement cnt. On cnt reaching 0, go to HOLD.
  - Shift latency = k+1 cycles, where k = clipped amount.
  - HOLD, out_ready=0: all outputs held stable.
  - HOLD, out_ready=1, no accept: go to IDLE.
  - HOLD, out_ready=1 and in_valid=1: transfer and accept in the same cycle, processed as from IDLE. Back-to-back issue gives 1 result per cycle for non-shift ops.
- Shift rules:
  - Amount >= WIDTH is clipped to WIDTH, giving result 0.
  - SHL by WIDTH: carry = a[0]. SHR by WIDTH: carry = a[WIDTH-1].
- Arithmetic:
  - ADD/SUB computed at WIDTH+1 bits; result is the low WIDTH bits.
  - overflow = operand signs equal (ADD) or differ (SUB), and result sign differs from a's sign.
- Flags zero and negative are always derived from the registered result, including shift results.
- Reset, any state including mid-shift:
  - Next cycle: state IDLE, in_ready=1, out_valid=0, result=0, all flags 0.
  - An in-flight operation is discarded, with no output.
- in_valid while BUSY is ignored (in_ready=0); the producer must hold its request.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: ADD and SUB saturate unsigned.
  - ADD with carry-out yields all-ones.
  - SUB with borrow yields 0.
  - carry/overflow still report the raw unsaturated condition; zero/negative follow the saturated result.
- Undefined: wrap-around arithmetic; no saturation logic synthesised.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic[2:0] alu_op_e (ADD..SHR, encodings above).
  - typedef enum alu_state_e {IDLE, BUSY, HOLD}.
  - packed struct alu_flags_t {carry, zero, negative, overflow}.
- Sub-module alu_core, WIDTH-parametrised and purely combinational: computes ADD/SUB/AND/OR/XOR/NOT result plus carry/overflow, and contains the ALU_SAT_EN logic.
- alu_seq owns the FSM, the shift counter/working register, and the output registers.

Test Plan (WIDTH=8):
- ADD a=8'hF0, b=8'h20 -> out_valid 1 cycle after accept; result 8'h10, carry 1, overflow 0, zero 0; with ALU_SAT_EN result 8'hFF, carry 1.
- SUB a=8'h05, b=8'h07 -> result 8'hFE, carry(borrow) 1, negative 1; ADD 8'h7F+8'h01 -> 8'h80, overflow 1, negative 1.
- SHR a=8'h81, b=1 -> result 8'h40, carry 1, out_valid 2 cycles after accept; SHL a=8'hA5, b=9 -> clipped to 8, result 8'h00, zero 1, carry 1, latency 9; b=0 -> result=a, latency 1.
- Backpressure: out_ready low 5 cycles in HOLD -> result/flags stable, in_ready 0; then out_ready=1 with in_valid=1 (XOR 8'hFF,8'h0F) -> transfer and accept same cycle, next result 8'hF0.
- Reset asserted during BUSY of SHL by 6 -> next cycle out_valid 0, in_ready 1, result 0, flags 0; no stale result ever presented.
- Random op/operand stream with random out_ready versus a reference model -> all results/flags match; no result lost or duplicated.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential ALU (opcodes, FSM states, flag bundle).
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        HOLD
    } alu_state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ADD/SUB/AND/OR/XOR/NOT datapath with carry and signed overflow.
// Ports: a_i, b_i operands; op_i opcode; res_o result; carry_o carry/borrow; ovf_o signed overflow.
// Macro ALU_SAT_EN: ADD/SUB saturate unsigned; carry_o/ovf_o still report the raw condition.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_e          op_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o,
    output logic             ovf_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH-1:0] raw;

    assign sum = {1'b0, a_i} + {1'b0, b_i};
    // Top bit of the widened difference is the unsigned borrow.
    assign dif = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        raw     = '0;
        carry_o = 1'b0;
        ovf_o   = 1'b0;
        case (op_i)
            OP_ADD: begin
                raw     = sum[WIDTH-1:0];
                carry_o = sum[WIDTH];
                ovf_o   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                raw     = dif[WIDTH-1:0];
                carry_o = dif[WIDTH];
                ovf_o   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (dif[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND: raw = a_i & b_i;
            OP_OR:  raw = a_i | b_i;
            OP_XOR: raw = a_i ^ b_i;
            OP_NOT: raw = ~a_i;
            default: raw = '0;
        endcase
`ifdef ALU_SAT_EN
        res_o = (op_i == OP_ADD && carry_o) ? '1 : (op_i == OP_SUB && carry_o) ? '0 : raw;
`else
        res_o = raw;
`endif
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes, registered result/flags, iterative shifts.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a, b, op on the input side;
//        out_valid/out_ready with result, carry, zero, negative, overflow on the output side.
// Macro ALU_SAT_EN (in alu_core): unsigned saturation for ADD/SUB.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    alu_state_e       state_q, state_d;
    alu_flags_t       flags_q, flags_d;
    alu_op_e          op_e;
    logic [WIDTH-1:0] result_q, result_d, work_q, work_d;
    logic [WIDTH-1:0] core_res, ld_res, sh_val;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_ld;
    logic             shr_q, shr_d;
    logic             accept, is_shift, ld, ld_c, ld_v, core_c, core_v, sh_out;

    assign op_e     = alu_op_e'(op);
    assign is_shift = (op_e == OP_SHL) || (op_e == OP_SHR);
    assign accept   = in_valid && in_ready;
    // Amounts of WIDTH or more all behave like WIDTH (result 0).
    assign cnt_ld   = (b >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(b);
    assign sh_val   = shr_q ? (work_q >> 1) : (work_q << 1);
    assign sh_out   = shr_q ? work_q[0] : work_q[WIDTH-1];

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a_i     (a),
        .b_i     (b),
        .op_i    (op_e),
        .res_o   (core_res),
        .carry_o (core_c),
        .ovf_o   (core_v)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        if (accept)
            state_d = (is_shift && cnt_ld != '0) ? BUSY : HOLD;
        else if (state_q == BUSY)
            state_d = (cnt_q == CNT_W'(1)) ? HOLD : BUSY;
        else if (state_q == HOLD && !out_ready)
            state_d = HOLD;
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || (state_q == HOLD && out_ready);
        out_valid = state_q == HOLD;
    end

    // ld marks the cycle a final value is written to the output registers.
    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        shr_d  = shr_q;
        ld     = 1'b0;
        ld_res = core_res;
        ld_c   = core_c;
        ld_v   = core_v;
        if (accept && is_shift) begin
            work_d = a;
            cnt_d  = cnt_ld;
            shr_d  = op_e == OP_SHR;
            ld     = cnt_ld == '0;
            ld_res = a;
            ld_c   = 1'b0;
            ld_v   = 1'b0;
        end else if (accept) begin
            ld = 1'b1;
        end else if (state_q == BUSY) begin
            work_d = sh_val;
            cnt_d  = cnt_q - CNT_W'(1);
            ld     = cnt_q == CNT_W'(1);
            ld_res = sh_val;
            ld_c   = sh_out;
            ld_v   = 1'b0;
        end
        result_d = ld ? ld_res : result_q;
        flags_d  = ld ? alu_flags_t'{carry: ld_c, zero: ld_res == '0,
                                     negative: ld_res[WIDTH-1], overflow: ld_v} : flags_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            shr_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            shr_q    <= shr_d;
        end
    end

    assign result   = result_q;
    assign carry    = flags_q.carry;
    assign zero     = flags_q.zero;
    assign negative = flags_q.negative;
    assign overflow = flags_q.overflow;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (directed cases, backpressure, reset mid-shift, random stream).
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready;
    logic         carry, zero, negative, overflow;
    logic [W-1:0] a, b, result;
    logic [2:0]   op;
    int           n_tests = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Returns {result, carry, zero, negative, overflow} from plain integer arithmetic.
    function automatic logic [W+3:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic [2:0] mop);
        int ua, ub, sa, sb, r, c, v, k, m;
        m  = 1 << W;
        ua = int'(ma);
        ub = int'(mb);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        c  = 0;
        v  = 0;
        r  = 0;
        k  = (ub > W) ? W : ub;
        case (mop)
            3'd0: begin
                r = ua + ub;
                c = (r >= m) ? 1 : 0;
                v = (sa + sb >= m / 2 || sa + sb < -m / 2) ? 1 : 0;
                r = r % m;
`ifdef ALU_SAT_EN
                if (c == 1) r = m - 1;
`endif
            end
            3'd1: begin
                c = (ua < ub) ? 1 : 0;
                v = (sa - sb >= m / 2 || sa - sb < -m / 2) ? 1 : 0;
                r = (ua - ub + m) % m;
`ifdef ALU_SAT_EN
                if (c == 1) r = 0;
`endif
            end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = (m - 1) - ua;
            3'd6: begin
                r = (ua << k) % m;
                c = (k == 0) ? 0 : (ua >> (W - k)) & 1;
            end
            default: begin
                r = ua >> k;
                c = (k == 0) ? 0 : (ua >> (k - 1)) & 1;
            end
        endcase
        return {r[W-1:0], c[0], r == 0, r >= m / 2, v[0]};
    endfunction

    // Called #1 after a rising edge; leaves the DUT in HOLD with out_ready high.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [2:0] top,
                          input int want_lat, input string tag);
        logic [W+3:0] e;
        int lat;
        a = ta;
        b = tb_v;
        op = top;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = model(ta, tb_v, top);
        check({tag, "_latency"}, lat, want_lat);
        check({tag, "_result"}, result, e[W+3:4]);
        check({tag, "_flags"}, {carry, zero, negative, overflow}, e[3:0]);
    endtask

    initial begin
        logic [W+3:0] e;
        logic [W+3:0] q[$];
        logic seen, acc, xfr;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        op = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_flags", {carry, zero, negative, overflow}, 0);

        run_op(8'hF0, 8'h20, 3'd0, 1, "add_carry");
        run_op(8'h05, 8'h07, 3'd1, 1, "sub_borrow");
        run_op(8'h7F, 8'h01, 3'd0, 1, "add_ovf");
        run_op(8'h80, 8'h01, 3'd1, 1, "sub_ovf");
        run_op(8'h81, 8'd1, 3'd7, 2, "shr1");
        run_op(8'hA5, 8'd9, 3'd6, 9, "shl_clip");
        run_op(8'h3C, 8'd0, 3'd6, 1, "shl0");
        run_op(8'h96, 8'd3, 3'd7, 4, "shr3");
        run_op(8'h81, 8'd8, 3'd7, 9, "shr8");
        run_op(8'hCC, 8'hAA, 3'd2, 1, "and");
        run_op(8'h0C, 8'hA0, 3'd3, 1, "or");
        run_op(8'h5A, 8'h00, 3'd5, 1, "not");

        run_op(8'h12, 8'h34, 3'd0, 1, "bp_add");
        out_ready = 1'b0;
        e = model(8'h12, 8'h34, 3'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_result", result, e[W+3:4]);
            check("bp_flags", {carry, zero, negative, overflow}, e[3:0]);
        end
        run_op(8'hFF, 8'h0F, 3'd4, 1, "b2b_xor");
        check("b2b_xor_const", result, 8'hF0);

        a = 8'h81;
        b = 8'd6;
        op = 3'd6;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy_out_valid", out_valid, 0);
        check("rst_busy_in_ready", in_ready, 1);
        check("rst_busy_result", result, 0);
        check("rst_busy_flags", {carry, zero, negative, overflow}, 0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        check("rst_no_stale", seen, 0);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!in_valid && $urandom_range(0, 2) != 0) begin
                a = W'($urandom);
                op = 3'($urandom_range(0, 7));
                b = (op >= 3'd6 && $urandom_range(0, 1) == 1) ? W'($urandom_range(0, 9)) : W'($urandom);
                in_valid = 1'b1;
            end
            out_ready = $urandom_range(0, 3) != 0;
            #1;
            acc = in_valid && in_ready;
            xfr = out_valid && out_ready;
            if (xfr) begin
                check("rnd_expected_present", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("rnd_result", result, e[W+3:4]);
                    check("rnd_flags", {carry, zero, negative, overflow}, e[3:0]);
                end
            end
            if (acc) q.push_back(model(a, b, op));
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && q.size() > 0; i++) begin
            #1;
            if (out_valid) begin
                e = q.pop_front();
                check("drain_result", result, e[W+3:4]);
                check("drain_flags", {carry, zero, negative, overflow}, e[3:0]);
            end
            @(posedge clk);
            #1;
        end
        check("rnd_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
